// File: rtl/ternary_dot_engine.sv
// Serial ternary-weight dot product over N_LANES lanes, then ReLU, right shift and saturation to OUT_W bits.
// Latency: start edge, N_LANES accumulate edges, one finish edge; out_valid is high after edge N_LANES+1.
// Backpressure: result is held in DONE until out_ready; start is ignored outside IDLE, with no queuing.
module ternary_dot_engine #(
  parameter int N_LANES = 16,
  parameter int DATA_W  = 8,
  parameter int WGT_W   = 2,
  parameter int ACC_W   = 14,
  parameter int OUT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_LANES*WGT_W-1:0]   weights,
  input  logic [N_LANES*DATA_W-1:0]  data,
  input  logic [3:0]                 shift,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           result,
  output logic [ACC_W-1:0]           acc_out
);

  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

  state_t                     state, state_nxt;
  logic [LANE_W-1:0]          lane;
  logic [ACC_W-1:0]           acc;
  logic [N_LANES*WGT_W-1:0]   w_snap;
  logic [N_LANES*DATA_W-1:0]  d_snap;
  logic [3:0]                 shift_snap;

  logic [WGT_W-1:0]           w_lane;
  logic [DATA_W-1:0]          d_lane;
  logic [ACC_W-1:0]           d_ext;
  logic [ACC_W-1:0]           prod;
  logic [ACC_W-1:0]           acc_pos;
  logic [ACC_W-1:0]           acc_shr;
  logic [OUT_W-1:0]           sat_val;

  assign w_lane = w_snap[lane*WGT_W +: WGT_W];
  assign d_lane = d_snap[lane*DATA_W +: DATA_W];
  assign d_ext  = ACC_W'(d_lane);

  // Ternary-style weights need no multiplier: select 0, +d, -2d or -d.
  always_comb begin
    prod = '0;
    case (w_lane)
      2'b01:   prod = d_ext;
      2'b10:   prod = -(d_ext << 1);
      2'b11:   prod = -d_ext;
      default: prod = '0;
    endcase
  end

  // A 4-bit shift can reach or exceed ACC_W; the logical shift then gives 0 naturally.
  assign acc_pos = acc[ACC_W-1] ? '0 : acc;
  assign acc_shr = acc_pos >> shift_snap;
  assign sat_val = (|acc_shr[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : acc_shr[OUT_W-1:0];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (lane == LAST_LANE) state_nxt = FINISH;
      FINISH:  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane       <= '0;
      acc        <= '0;
      w_snap     <= '0;
      d_snap     <= '0;
      shift_snap <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      acc_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_snap     <= weights;
            d_snap     <= data;
            shift_snap <= shift;
            acc        <= '0;
            lane       <= '0;
          end
        end
        RUN: begin
          acc  <= acc + prod;
          lane <= lane + 1'b1;
        end
        FINISH: begin
          acc_out   <= acc;
          result    <= sat_val;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ternary_dot_engine.md
Name: ternary_dot_engine

Overview:
- Downstream compute stage of the SPI operand loaders.
- Consumes the 32-bit weight register (16 lanes × 2-bit signed weights) and the 128-bit data register (16 lanes × 8-bit unsigned activations).
- Computes one neuron output serially, one lane per cycle, then applies ReLU, shift and saturation to 8 bits.
- Result is presented on a valid/ready handshake; it feeds the output pins or a next layer.

Parameters:
- N_LANES, 16, number of weight/data lane pairs.
- DATA_W, 8, activation width, unsigned.
- WGT_W, 2, weight width, two's complement.
- ACC_W, 14, signed accumulator width. Must hold the range -N_LANES·2·(2^DATA_W−1) .. +N_LANES·(2^DATA_W−1).
- OUT_W, 8, result width, unsigned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  request to begin a dot product; honoured only in IDLE.
- weights  in  N_LANES*WGT_W  lane i at bits [i*WGT_W +: WGT_W].
- data  in  N_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- shift  in  4  right-shift applied after ReLU; sampled with start.
- busy  out  1  high whenever state ≠ IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  OUT_W  saturated, shifted ReLU of the accumulator.
- acc_out  out  ACC_W  raw signed accumulator; valid while out_valid=1.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, lane counter=0, acc=0, busy=0, out_valid=0, result=0, acc_out=0. Operand snapshots cleared. Reset wins over every other input, including mid-RUN and mid-DONE.
- Weight decode: 00=0, 01=+1, 10=−2, 11=−1. Each product is sign-extended to ACC_W before the add.
- States: IDLE, RUN, FINISH, DONE.
- IDLE:
  - On an edge with start=1: snapshot weights, data and shift into internal registers; acc←0; lane←0; go RUN.
  - start=0: remain in IDLE.
- RUN:
  - Each edge: acc←acc+w[lane]·d[lane], lane←lane+1. Lanes are processed from 0 up to N_LANES−1.
  - On the edge that processes lane N_LANES−1: go FINISH.
  - Exactly N_LANES accumulate edges.
  - Input ports are ignored during RUN. Upstream may reload its SPI registers freely; the snapshot isolates the computation.
- FINISH (one cycle, on its edge):
  - acc_out←acc.
  - result←min(2^OUT_W−1, (acc<0 ? 0 : acc)>>shift_snap).
  - out_valid←1; go DONE.
- DONE:
  - result, acc_out and out_valid are held stable until an edge with out_ready=1.
  - On that edge: out_valid←0, go IDLE.
  - result and acc_out retain their last values after leaving DONE.
- Latency: start sampled at edge E0 → accumulate edges E1..E16 → out_valid=1 after edge E17. With out_ready held high, busy drops after E18.
- start asserted in any state other than IDLE is ignored; no queuing.
- A start asserted in the same cycle as the DONE handshake is ignored; the next start is accepted from IDLE.
- busy=1 from the edge after start is accepted until the edge that completes the handshake.
- Arithmetic:
  - Accumulator never overflows with the default parameters: range −8160..+4080 fits in 14 bits.
  - shift ≥ ACC_W yields 0.
  - Saturation is applied after the shift.

Test Plan:
- Basic: weights=0x55555555 (all +1), data=16×0x01, shift=0, start pulse → out_valid rises after E17; acc_out=16, result=16. With out_ready=1, out_valid clears the next edge.
- ReLU: weights=0xFFFFFFFF (all −1), data=16×0x10, shift=0 → acc_out=−256 (0x3F00), result=0.
- Saturation: weights=0x55555555, data=16×0xFF → acc_out=4080. shift=3 gives result=255 (saturated); shift=4 gives result=255 (exact); shift=5 gives result=127.
- Mixed lanes: weights=0x00000009 (lane0=+1, lane1=−2), data lane0=0x64, lane1=0x14, others 0, shift=0 → acc_out=60, result=60.
- Backpressure/isolation:
  - Setup: the Basic operands, with weights and data toggled to 0x0 during RUN, start pulsed during RUN and DONE, and out_ready held 0 for 5 cycles after out_valid.
  - Required: result stays 16 throughout, busy=1, extra starts ignored. On out_ready=1: IDLE, then a new start is accepted normally.
- Reset mid-operation: rst_n=0 for one edge while lane=7 in RUN → next cycle busy=0, out_valid=0, result=0, acc_out=0. A subsequent start with the Mixed-lanes vector gives result=60.
